// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and the
// memory controller instruction port; a miss issues one word request and fills.
module icache #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  input  logic        clear,
  output logic        fetch_ready,
  output logic [31:0] fetch_ins,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_ins
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MISS = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]          state_reg, state_next;
  logic [LINES-1:0]    valid_reg;
  logic [TAG_BITS-1:0] tag_mem [LINES];
  logic [31:0]         data_mem [LINES];

  logic                fetch_ready_reg, fetch_ready_next;
  logic [31:0]         fetch_ins_reg;
  logic [31:0]         mem_addr_reg, mem_addr_next;

  logic [31:0]           pc_word;
  logic [INDEX_BITS-1:0] req_idx, fill_idx;
  logic [TAG_BITS-1:0]   req_tag, fill_tag;
  logic                  hit, accept, waiting, fill_en;
  logic                  load_hit, load_fill;

  assign pc_word  = {fetch_pc[31:2], 2'b00};
  assign req_idx  = pc_word[INDEX_BITS+1:2];
  assign req_tag  = pc_word[31:INDEX_BITS+2];
  assign fill_idx = mem_addr_reg[INDEX_BITS+1:2];
  assign fill_tag = mem_addr_reg[31:INDEX_BITS+2];

  assign hit     = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);
  assign accept  = fetch_req && !clear;
  assign waiting = (state_reg == MISS) || (state_reg == DROP);
  assign fill_en = waiting && mem_done;

  // Dropping the request on the completion cycle keeps the controller from
  // seeing a request level on the edge that ends the transaction.
  assign mem_req     = waiting && !mem_done;
  assign mem_addr    = mem_addr_reg;
  assign fetch_ready = fetch_ready_reg;
  assign fetch_ins   = fetch_ins_reg;

  always_comb begin
    state_next       = state_reg;
    fetch_ready_next = 1'b0;
    mem_addr_next    = mem_addr_reg;
    load_hit         = 1'b0;
    load_fill        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (hit) begin
            fetch_ready_next = 1'b1;
            load_hit         = 1'b1;
          end else begin
            mem_addr_next = pc_word;
            state_next    = MISS;
          end
        end
      end
      MISS: begin
        if (mem_done) begin
          // A clear on the completion edge still fills, but the word is stale.
          fetch_ready_next = !clear;
          load_fill        = !clear;
          state_next       = IDLE;
        end else if (clear) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (mem_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      fetch_ready_reg <= 1'b0;
      fetch_ins_reg   <= 32'd0;
      mem_addr_reg    <= 32'd0;
    end else if (rdy) begin
      state_reg       <= state_next;
      fetch_ready_reg <= fetch_ready_next;
      mem_addr_reg    <= mem_addr_next;
      if (load_hit) begin
        fetch_ins_reg <= data_mem[req_idx];
      end else if (load_fill) begin
        fetch_ins_reg <= mem_ins;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_reg[gi] <= 1'b0;
        end else if (rdy && fill_en && (fill_idx == INDEX_BITS'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Tag and data storage carry no reset; the valid bits gate every lookup.
  always_ff @(posedge clk) begin
    if (rdy && fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem_ins;
    end
  end

endmodule
